// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: operation encoding shared by the alu_seq pipeline, its
// combinational core and the testbench.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_XOR     = 3'b010;
  localparam logic [2:0] OP_AND     = 3'b011;
  localparam logic [2:0] OP_OR      = 3'b100;
  localparam logic [2:0] OP_CMP     = 3'b101;
  localparam logic [2:0] OP_ACC_XOR = 3'b110;
  localparam logic [2:0] OP_ACC_CLR = 3'b111;

  typedef enum logic [2:0] {
    ADD     = OP_ADD,
    SUB     = OP_SUB,
    XOR_OP  = OP_XOR,
    AND_OP  = OP_AND,
    OR_OP   = OP_OR,
    CMP     = OP_CMP,
    ACC_XOR = OP_ACC_XOR,
    ACC_CLR = OP_ACC_CLR
  } op_e;

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: purely combinational datapath evaluated in stage 2.
// Optional accumulator ops are enabled by the ALU_SEQ_ACC_EN macro; without
// it the accumulator ports do not exist and ops 110/111 raise err.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef ALU_SEQ_ACC_EN
  input  logic [WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0] acc_next_o,
`endif
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             err_o
);

  // Decode the operation and compute the result plus flags.
  always_comb begin
    y_o     = '0;
    carry_o = 1'b0;
    err_o   = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    acc_next_o = acc_i;
`endif
    case (op_i)
      ADD: begin
        {carry_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
      end
      SUB: begin
        y_o     = a_i - b_i;
        carry_o = (a_i < b_i);
      end
      XOR_OP: y_o = a_i ^ b_i;
      AND_OP: y_o = a_i & b_i;
      OR_OP:  y_o = a_i | b_i;
      CMP: begin
        // bit 0: less-than, bit 1: equal, upper bits stay zero
        y_o[0] = (a_i < b_i);
        y_o[1] = (a_i == b_i);
      end
`ifdef ALU_SEQ_ACC_EN
      ACC_XOR: begin
        acc_next_o = acc_i ^ a_i;
        y_o        = acc_i ^ a_i;
      end
      ACC_CLR: begin
        acc_next_o = '0;
        y_o        = '0;
      end
`else
      ACC_XOR: err_o = 1'b1;
      ACC_CLR: err_o = 1'b1;
`endif
      default: err_o = 1'b1;
    endcase
    zero_o = (y_o == '0);
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: two-stage pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 captures op/a/b, stage 2 registers the core's result and flags.
// Define ALU_SEQ_ACC_EN to build the accumulator and its two ops.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid must keep its data stable until that edge,
// and ready never depends combinationally on the same side's valid.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  // Whole pipeline moves together unless a result is waiting on the consumer.
  logic advance;
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q,    s1_op_d;
  logic [WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [WIDTH-1:0] s1_b_q,     s1_b_d;

  // Stage 2 (output) registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q,         y_d;
  logic             carry_q,     carry_d;
  logic             zero_q,      zero_d;
  logic             err_q,       err_d;

  // Core results for the operation sitting in stage 1
  logic [WIDTH-1:0] core_y;
  logic             core_carry;
  logic             core_zero;
  logic             core_err;

`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] core_acc_next;
`endif

  alu_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op_i      (s1_op_q),
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
`ifdef ALU_SEQ_ACC_EN
    .acc_i     (acc_q),
    .acc_next_o(core_acc_next),
`endif
    .y_o       (core_y),
    .carry_o   (core_carry),
    .zero_o    (core_zero),
    .err_o     (core_err)
  );

  // Stage 1 next state: capture a new operand set whenever the pipe advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = op_e'(op);
        s1_a_d  = a;
        s1_b_d  = b;
      end
    end
  end

  // Stage 2 next state: register the core result as stage 1 drains into it.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d     = core_y;
        carry_d = core_carry;
        zero_d  = core_zero;
        err_d   = core_err;
      end
    end
  end

`ifdef ALU_SEQ_ACC_EN
  // Accumulator commits only when its op actually moves into stage 2.
  always_comb begin
    acc_d = acc_q;
    if (advance && s1_valid_q) begin
      acc_d = core_acc_next;
    end
  end
`endif

  // All pipeline state, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table, hand-written pipeline sequences and randomized
// traffic for alu_seq (WIDTH = 8), checked against a reference model.
// Honors ALU_SEQ_ACC_EN the same way the design does.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;
  localparam int RW    = WIDTH + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic             err;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .carry    (carry),
    .zero     (zero),
    .err      (err)
  );

  logic [RW-1:0] cur;
  assign cur = {carry, zero, err, y};

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];
  int acc_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pk(input int yv, input bit c, input bit z, input bit e);
    logic [WIDTH-1:0] yy;
    yy = WIDTH'(yv);
    return {c, z, e, yy};
  endfunction

  // Reference model: plain integer arithmetic, one call per accepted operation
  // in issue order (results leave in the same order, so acc evolves identically).
  function automatic logic [RW-1:0] model(input logic [2:0] o, input int av, input int bv);
    int  r = 0;
    bit  c = 0;
    bit  e = 0;
    case (o)
      OP_ADD: begin r = (av + bv) % MOD; c = (av + bv) >= MOD; end
      OP_SUB: begin r = (av - bv + MOD) % MOD; c = av < bv; end
      OP_XOR: r = av ^ bv;
      OP_AND: r = av & bv;
      OP_OR:  r = av | bv;
      OP_CMP: r = (av < bv ? 1 : 0) + (av == bv ? 2 : 0);
`ifdef ALU_SEQ_ACC_EN
      OP_ACC_XOR: begin acc_m = acc_m ^ av; r = acc_m; end
      OP_ACC_CLR: begin acc_m = 0; r = 0; end
`else
      default: e = 1;
`endif
    endcase
    return pk(r, c, r == 0, e);
  endfunction

  // Monitor: log accepts into the expected queue, compare deliveries, and
  // confirm outputs stay frozen while the consumer stalls.
  bit            prev_stall = 0;
  logic [RW-1:0] prev_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(cur), 32'(prev_out));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 32'(exp_q.size()), 32'd1);
        else check("sb_result", 32'(cur), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, int'(a), int'(b)));
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
  endtask

  task automatic check_out(input string name, input logic [7:0] ey, input bit ec,
                           input bit ez, input bit ee);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_y"}, 32'(y), 32'(ey));
    check({name, "_flags"}, 32'({carry, zero, err}), 32'({ec, ez, ee}));
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    bit         c;
    bit         z;
  } vec_t;
  vec_t tbl[14];

  logic [7:0] acc_ey[4];
  bit         acc_ez[4];
  bit         acc_ee[4];

  initial begin
    int cnt;
    bit acc_ok;

    tbl[0]  = '{OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    tbl[1]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    tbl[2]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    tbl[3]  = '{OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{OP_SUB, 8'h03, 8'h04, 8'hFF, 1'b1, 1'b0};
    tbl[5]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};
    tbl[6]  = '{OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    tbl[7]  = '{OP_XOR, 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    tbl[9]  = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{OP_OR,  8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{OP_CMP, 8'h12, 8'h12, 8'h02, 1'b0, 1'b0};
    tbl[12] = '{OP_CMP, 8'h01, 8'h80, 8'h01, 1'b0, 1'b0};
    tbl[13] = '{OP_CMP, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1};

`ifdef ALU_SEQ_ACC_EN
    acc_ey = '{8'h0F, 8'h33, 8'h00, 8'h01};
    acc_ez = '{1'b0, 1'b0, 1'b1, 1'b0};
    acc_ee = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    acc_ey = '{8'h00, 8'h00, 8'h00, 8'h00};
    acc_ez = '{1'b1, 1'b1, 1'b1, 1'b1};
    acc_ee = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'(cur), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ---- directed table: latency is exactly two edges after presenting ----
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      put(tbl[i].op, tbl[i].a, tbl[i].b);
      cyc();
      check($sformatf("tbl%0d_lat1", i), 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      cyc();
      check_out($sformatf("tbl%0d", i), tbl[i].y, tbl[i].c, tbl[i].z, 1'b0);
      cyc();
      check($sformatf("tbl%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // ---- back-to-back SUBs on consecutive cycles ----
    put(OP_SUB, 8'h05, 8'h05);
    cyc();
    put(OP_SUB, 8'h03, 8'h04);
    cyc();
    check_out("b2b_first", 8'h00, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b0;
    cyc();
    check_out("b2b_second", 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc();
    check("b2b_empty", 32'(out_valid), 32'd0);

    // ---- consumer stall with both stages full, extra offer must wait ----
    out_ready = 1'b0;
    put(OP_ADD, 8'h01, 8'h02);
    cyc();
    put(OP_XOR, 8'hAA, 8'h55);
    cyc();
    check_out("stall_first", 8'h03, 1'b0, 1'b0, 1'b0);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    put(OP_OR, 8'h0F, 8'h30);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_out($sformatf("stall_hold%0d", i), 8'h03, 1'b0, 1'b0, 1'b0);
      check($sformatf("stall_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_out("stall_second", 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc();
    check_out("stall_third", 8'h3F, 1'b0, 1'b0, 1'b0);
    cyc();
    check("stall_empty", 32'(out_valid), 32'd0);

    // ---- accumulator chain issued back-to-back ----
    put(OP_ACC_XOR, 8'h0F, 8'hEE);
    cyc();
    put(OP_ACC_XOR, 8'h3C, 8'h11);
    cyc();
    check_out("acc0", acc_ey[0], 1'b0, acc_ez[0], acc_ee[0]);
    put(OP_ACC_CLR, 8'h99, 8'h77);
    cyc();
    check_out("acc1", acc_ey[1], 1'b0, acc_ez[1], acc_ee[1]);
    put(OP_ACC_XOR, 8'h01, 8'h00);
    cyc();
    check_out("acc2", acc_ey[2], 1'b0, acc_ez[2], acc_ee[2]);
    in_valid = 1'b0;
    cyc();
    check_out("acc3", acc_ey[3], 1'b0, acc_ez[3], acc_ee[3]);
    cyc();

    // ---- reset with two operations in flight ----
    out_ready = 1'b0;
    put(OP_ACC_XOR, 8'h77, 8'h00);
    cyc();
    put(OP_ACC_XOR, 8'h11, 8'h00);
    cyc();
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    acc_m = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_outputs", 32'(cur), 32'd0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (out_valid) cnt++;
    end
    check("midrst_no_output", 32'(cnt), 32'd0);
    put(OP_ACC_XOR, 8'h5A, 8'h00);
    cyc();
    in_valid = 1'b0;
    cyc();
`ifdef ALU_SEQ_ACC_EN
    check_out("midrst_acc", 8'h5A, 1'b0, 1'b0, 1'b0);
`else
    check_out("midrst_acc", 8'h00, 1'b0, 1'b1, 1'b1);
`endif
    cyc();

    // ---- randomized traffic with random back-pressure ----
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !acc_ok) || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) b = a;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      cyc();
      cnt++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  input  1  operand set offered.
REQ-005 Port: in_ready  output  1  block can accept an operand set this cycle.
REQ-006 Port: op  input  3  operation select, encoding per REQ-012.
REQ-007 Port: a  input  WIDTH  operand A, unsigned.
REQ-008 Port: b  input  WIDTH  operand B, unsigned.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: y, carry, zero, err  outputs  WIDTH,1,1,1  result, carry/borrow, result-is-zero, illegal-op flag.

Function
REQ-012 Op encoding: 000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 CMP, 110 ACC_XOR, 111 ACC_CLR.
REQ-013 ADD: y = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
REQ-014 SUB: y = (a-b) mod 2^WIDTH; carry = 1 when a < b (borrow).
REQ-015 XOR/AND/OR: bitwise; carry = 0.
REQ-016 CMP: y = {0..., a<b}; y[1] = (a==b); upper bits 0; carry = 0.
REQ-017 ACC_XOR: internal WIDTH-bit acc <= acc ^ a; y = updated acc; b ignored.
REQ-018 ACC_CLR: acc <= 0; y = 0.
REQ-019 zero = (y == 0) for every op; err = 0 for every legal op.
REQ-020 Two-stage pipeline: stage 1 registers op/a/b on accept; stage 2 computes and registers y/flags; out_valid rises exactly 2 cycles after the accepting edge when not stalled.
REQ-021 Accept occurs on a rising edge with in_valid && in_ready; advance = !out_valid || out_ready; in_ready = advance.
REQ-022 Throughput one operation per cycle with out_ready held high; results emerge in issue order.
REQ-023 While out_valid && !out_ready, both stages hold; y/carry/zero/err stay bit-stable.
REQ-024 acc updates only when its op moves from stage 1 to stage 2; back-to-back ACC ops see each predecessor's result.
REQ-025 in_valid while in_ready = 0 is not accepted; producer must hold data.
REQ-026 No bubble insertion: a stage 2 drain concurrent with a stage 1 fill in the same cycle loses nothing.

Reset
REQ-027 rst_n low clears immediately: out_valid = 0, both stage valids = 0, y = 0, carry = 0, zero = 0, err = 0, acc = 0.
REQ-028 Reset mid-operation discards all in-flight operations; no result is emitted after release.
REQ-029 in_ready = 1 from the first edge after rst_n release.

Configuration
REQ-030 Macro ALU_SEQ_ACC_EN defined: ops 110/111 behave per REQ-017/018 and acc exists.
REQ-031 ALU_SEQ_ACC_EN undefined: no acc register; ops 110/111 produce y = 0, carry = 0, zero = 1, err = 1, with normal latency and handshake.

Structure
REQ-032 Shared package alu_seq_pkg holds the op encoding constants and the op enum typedef; no other constants.
REQ-033 One sub-module alu_seq_core: purely combinational op/a/b/acc -> y/carry/zero/err/acc_next, instantiated in stage 2.

Verification (WIDTH = 8)
REQ-034 ADD a=0xF0 b=0x20, out_ready=1 -> 2 cycles later y=0x10, carry=1, zero=0.
REQ-035 SUB a=0x05 b=0x05 then a=0x03 b=0x04 back-to-back -> y=0x00 zero=1 carry=0, then y=0xFF carry=1, consecutive cycles.
REQ-036 out_ready=0 for 3 cycles with two ops issued -> in_ready=0 while both stages full, first result held stable, both delivered in order after release.
REQ-037 ALU_SEQ_ACC_EN: ACC_XOR a=0x0F, ACC_XOR a=0x3C, ACC_CLR, ACC_XOR a=0x01 -> y=0x0F, 0x33, 0x00, 0x01; undefined -> err=1 zero=1 each.
REQ-038 rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no result after release, acc=0.
REQ-039 CMP a=0x12 b=0x12 then a=0x01 b=0x80 -> y=0x02, then y=0x01.
